// File: rtl/bp_cce_ucode_ctrl.sv
// Arbiter for the CCE microcode RAM programming port: single-word config
// reads/writes and a streaming bulk loader, both locked out in normal mode.
module bp_cce_ucode_ctrl #(
  parameter int cce_pc_width_p    = 8,
  parameter int cce_instr_width_p = 48
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         mode_normal_i,
  input  logic                         cfg_v_i,
  input  logic                         cfg_w_i,
  input  logic [cce_pc_width_p-1:0]    cfg_addr_i,
  input  logic [cce_instr_width_p-1:0] cfg_data_i,
  output logic                         cfg_ready_o,
  output logic                         cfg_v_o,
  output logic [cce_instr_width_p-1:0] cfg_data_o,
  input  logic                         cfg_yumi_i,
  input  logic                         load_start_i,
  input  logic [cce_pc_width_p-1:0]    load_base_i,
  input  logic [cce_pc_width_p:0]      load_count_i,
  input  logic                         load_v_i,
  input  logic [cce_instr_width_p-1:0] load_data_i,
  output logic                         load_ready_o,
  output logic                         load_done_o,
  output logic                         busy_o,
  output logic                         ucode_v_o,
  output logic                         ucode_w_o,
  output logic [cce_pc_width_p-1:0]    ucode_addr_o,
  output logic [cce_instr_width_p-1:0] ucode_data_o,
  input  logic [cce_instr_width_p-1:0] ucode_data_i
);

  typedef enum logic [2:0] {IDLE, BULK, RD_WAIT, RD_RESP, DONE} state_e;

  state_e                         state_q, state_d;
  logic [cce_pc_width_p-1:0]      addr_q, addr_d;
  logic [cce_pc_width_p:0]        rem_q, rem_d;
  logic [cce_instr_width_p-1:0]   data_q, data_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    data_d       = data_q;
    cfg_ready_o  = 1'b0;
    cfg_v_o      = 1'b0;
    load_ready_o = 1'b0;
    load_done_o  = 1'b0;
    ucode_v_o    = 1'b0;
    ucode_w_o    = 1'b0;
    ucode_addr_o = addr_q;
    ucode_data_o = load_data_i;

    case (state_q)
      IDLE: begin
        // bulk start outranks a config request arriving in the same cycle
        if (load_start_i && !mode_normal_i) begin
          addr_d  = load_base_i;
          rem_d   = load_count_i;
          state_d = (load_count_i != '0) ? BULK : DONE;
        end else begin
          cfg_ready_o = !mode_normal_i && !load_start_i;
          if (cfg_v_i && cfg_ready_o) begin
            ucode_v_o    = 1'b1;
            ucode_w_o    = cfg_w_i;
            ucode_addr_o = cfg_addr_i;
            ucode_data_o = cfg_data_i;
            if (!cfg_w_i) state_d = RD_WAIT;
          end
        end
      end
      BULK: begin
        load_ready_o = 1'b1;
        if (load_v_i) begin
          ucode_v_o = 1'b1;
          ucode_w_o = 1'b1;
          addr_d    = addr_q + 1'b1;
          rem_d     = rem_q - 1'b1;
          if (rem_q == (cce_pc_width_p+1)'(1)) state_d = DONE;
        end
      end
      RD_WAIT: begin
        data_d  = ucode_data_i;
        state_d = RD_RESP;
      end
      RD_RESP: begin
        cfg_v_o = 1'b1;
        if (cfg_yumi_i) state_d = IDLE;
      end
      DONE: begin
        load_done_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // handshakes must fall with reset itself, not at the next edge
    if (reset_i) begin
      cfg_ready_o  = 1'b0;
      cfg_v_o      = 1'b0;
      load_ready_o = 1'b0;
      load_done_o  = 1'b0;
      ucode_v_o    = 1'b0;
      ucode_w_o    = 1'b0;
    end
  end

  assign cfg_data_o = data_q;
  assign busy_o     = (state_q != IDLE);

endmodule
